bit_pattern_gen: RTL and testbench
==================================

BIT_PATTERN_GEN -- requirements
Module: bit_pattern_gen

Interface
REQ-001 Parameter: WIDTH, default 32, pattern register width in bits (2..64).
REQ-002 Parameter: LW, default 6, i_len width; SHALL equal clog2(WIDTH)+1.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_load  input  1  capture i_pattern/i_len/i_loop into internal registers.
REQ-006 i_pattern  input  WIDTH  bit pattern; bit 0 transmitted first.
REQ-007 i_len  input  LW  number of bits to transmit per pass.
REQ-008 i_loop  input  1  1 = repeat pattern continuously, 0 = single pass.
REQ-009 i_start  input  1  one-cycle request to begin transmission.
REQ-010 i_stop  input  1  abort current transmission.
REQ-011 o_val  output  1  serial bit stream to the downstream detector i_val input.
REQ-012 o_vld  output  1  o_val carries a pattern bit this cycle.
REQ-013 o_busy  output  1  state is RUN.
REQ-014 o_done  output  1  one-cycle pulse on completion of a single pass.

Function
REQ-015 States SHALL be IDLE and RUN only; a bit index counter idx (LW bits) tracks position.
REQ-016 Stored length SHALL be clamped at load: i_len > WIDTH stores WIDTH; i_len = 0 stores 0.
REQ-017 i_load SHALL be accepted only in IDLE; in RUN it is ignored and stored values are unchanged.
REQ-018 IDLE -> RUN when i_start=1, i_stop=0 and effective length != 0; idx set to 0.
REQ-019 i_start with effective length 0 SHALL be ignored; state stays IDLE, o_done stays 0.
REQ-020 i_load and i_start in the same IDLE cycle: the newly loaded pattern/len/loop SHALL be used for that run.
REQ-021 i_start in RUN SHALL be ignored.
REQ-022 Latency: start sampled at edge k -> first bit (pattern[0]) on o_val with o_vld=1 from edge k until edge k+1.
REQ-023 In RUN, o_val SHALL equal stored_pattern[idx], registered; idx increments by 1 each cycle.
REQ-024 At idx = len-1 with loop=1: idx wraps to 0 next cycle, no gap, o_vld stays 1, o_done stays 0.
REQ-025 At idx = len-1 with loop=0: next cycle state IDLE, o_vld=0, o_done=1 for exactly that one cycle.
REQ-026 i_stop in RUN: next cycle state IDLE, o_vld=0, o_val=0, o_done=0; remaining bits discarded.
REQ-027 i_stop and i_start in the same IDLE cycle: stop wins, no run starts.
REQ-028 i_stop coinciding with the last bit of a single pass: abort takes priority, o_done=0.
REQ-029 Whenever o_vld=0, o_val SHALL be 0.
REQ-030 o_busy SHALL be 1 exactly in cycles where o_vld=1.
REQ-031 len=1, loop=1 SHALL output pattern[0] continuously every cycle.

Reset
REQ-032 rst=1 at an edge SHALL force: state IDLE, idx 0, stored pattern 0, stored len 0, stored loop 0.
REQ-033 Outputs during and after reset: o_val=0, o_vld=0, o_busy=0, o_done=0.
REQ-034 rst asserted mid-RUN SHALL abort without an o_done pulse; rst has priority over all inputs.
REQ-035 i_start after reset with no prior load SHALL be ignored (len 0).

Verification
REQ-036 Load 32'hAAAA_B2CD, len 32, loop 0, start -> o_val = bits 0..31 LSB first over 32 cycles, o_done pulse on cycle 33, o_vld=0 after.
REQ-037 Load 8'b1011_0010 (WIDTH 32, upper bits 0), len 8, loop 1 -> repeating 0,1,0,0,1,1,0,1 with no gap for at least 3 passes, o_done never 1.
REQ-038 Start run len 16, assert i_stop after 5 bits -> o_vld=0 next cycle, o_done=0; i_load in RUN beforehand leaves stream unchanged.
REQ-039 i_load with len 40 -> stored 32; i_load with len 0 then i_start -> stays IDLE, o_vld=0.
REQ-040 rst pulse at bit 10 of a looping run -> all outputs 0 next cycle; subsequent i_start ignored until new i_load.
REQ-041 i_load+i_start same cycle, then i_stop+i_start same cycle in IDLE -> first runs new pattern, second does not start.

Source files
------------

// File: rtl/bit_pattern_gen_if.sv
// Bit pattern generator bus.
// Control/pattern inputs and serial stream outputs.
interface bit_pattern_gen_if #(
  parameter int WIDTH = 32,
  parameter int LW    = 6
);
  logic             i_load;
  logic [WIDTH-1:0] i_pattern;
  logic [LW-1:0]    i_len;
  logic             i_loop;
  logic             i_start;
  logic             i_stop;
  logic             o_val;
  logic             o_vld;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_load,
    output i_pattern,
    output i_len,
    output i_loop,
    output i_start,
    output i_stop,
    input  o_val,
    input  o_vld,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_load,
    input  i_pattern,
    input  i_len,
    input  i_loop,
    input  i_start,
    input  i_stop,
    output o_val,
    output o_vld,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/bit_pattern_gen.sv
// Serial bit pattern generator, LSB first.
// Single pass or continuous loop, abortable.
module bit_pattern_gen #(
  parameter int WIDTH = 32,
  parameter int LW    = 6
) (
  input  logic           clk,
  input  logic           rst,
  bit_pattern_gen_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
  logic             loop_q, loop_d;
  logic             val_q, val_d;
  logic             done_q, done_d;

  logic             ld;
  logic [LW-1:0]    ld_len;
  logic [WIDTH-1:0] eff_pat;
  logic [LW-1:0]    eff_len;
  logic             last;

  function automatic logic [LW-1:0] clamp(
    input logic [LW-1:0] l
  );
    if (l > LW'(WIDTH))
      return LW'(WIDTH);
    return l;
  endfunction

  function automatic logic bit_at(
    input logic [WIDTH-1:0] p,
    input logic [LW-1:0]    n
  );
    logic b;
    b = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (n == LW'(i))
        b = p[i];
    return b;
  endfunction

  // Load is only honoured while idle; a same-cycle start sees it.
  always_comb begin
    ld      = bus.i_load && (state_q == IDLE);
    ld_len  = clamp(bus.i_len);
    eff_pat = ld ? bus.i_pattern : pat_q;
    eff_len = ld ? ld_len : len_q;
    last    = (idx_q == len_q - LW'(1));
  end

  // Next-state: stop beats start and beats end-of-pass.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    len_d   = len_q;
    loop_d  = loop_q;
    val_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld) begin
          pat_d  = bus.i_pattern;
          len_d  = ld_len;
          loop_d = bus.i_loop;
        end
        if (bus.i_start && !bus.i_stop &&
            eff_len != '0) begin
          state_d = RUN;
          idx_d   = '0;
          val_d   = eff_pat[0];
        end
      end
      RUN: begin
        if (bus.i_stop) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (last && loop_q) begin
          idx_d = '0;
          val_d = pat_q[0];
        end else if (last) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + LW'(1);
          val_d = bit_at(pat_q, idx_q + LW'(1));
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_val  = val_q;
  assign bus.o_vld  = (state_q == RUN);
  assign bus.o_busy = (state_q == RUN);
  assign bus.o_done = done_q;

  a_val_quiet: assert property (
    @(posedge clk) !bus.o_vld |-> !bus.o_val);
  a_done_idle: assert property (
    @(posedge clk) bus.o_done |-> !bus.o_vld);
  a_len_ok: assert property (
    @(posedge clk) len_q <= LW'(WIDTH));

endmodule

// File: tb/tb_bit_pattern_gen.sv
// Bench for bit_pattern_gen: time-based model,
// directed scenarios and random traffic.
module tb_bit_pattern_gen;
  localparam int WIDTH = 32;
  localparam int LW    = 6;

  logic clk;
  logic rst;
  int   chk_cnt;
  int   pass_cnt;

  bit_pattern_gen_if #(.WIDTH(WIDTH), .LW(LW)) bus ();

  bit_pattern_gen #(.WIDTH(WIDTH), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] got,
                     logic [63:0] want);
    chk_cnt++;
    if (got === want)
      pass_cnt++;
    else
      $display("FAIL %s got %h want %h", name, got, want);
  endtask

  // Model: stored regs plus elapsed time since start.
  logic [WIDTH-1:0] m_pat;
  int               m_len;
  logic             m_loop;
  logic             m_run;
  int               m_t;
  logic             m_done;

  initial begin
    logic s_rst, s_ld, s_st, s_sp, s_lp;
    logic [WIDTH-1:0] s_pat;
    int s_len;
    logic [3:0] exp_o, got_o;
    logic e_val;
    m_pat = '0; m_len = 0; m_loop = 0;
    m_run = 0; m_t = 0; m_done = 0;
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_ld  = bus.i_load;
      s_st  = bus.i_start;
      s_sp  = bus.i_stop;
      s_lp  = bus.i_loop;
      s_pat = bus.i_pattern;
      s_len = int'(bus.i_len);
      if (s_rst) begin
        m_pat = '0; m_len = 0; m_loop = 0;
        m_run = 0; m_t = 0; m_done = 0;
      end else begin
        m_done = 0;
        if (!m_run) begin
          if (s_ld) begin
            m_pat  = s_pat;
            m_len  = (s_len > WIDTH) ? WIDTH : s_len;
            m_loop = s_lp;
          end
          if (s_st && !s_sp && m_len != 0) begin
            m_run = 1;
            m_t   = 0;
          end
        end else if (s_sp) begin
          m_run = 0;
        end else begin
          m_t++;
          if (!m_loop && m_t == m_len) begin
            m_run  = 0;
            m_done = 1;
          end
        end
      end
      e_val = m_run ? m_pat[m_t % m_len] : 1'b0;
      exp_o = {e_val, m_run, m_run, m_done};
      @(negedge clk);
      got_o = {bus.o_val, bus.o_vld,
               bus.o_busy, bus.o_done};
      chk("model{val,vld,busy,done}", 64'(got_o),
          64'(exp_o));
    end
  end

  task automatic step();
    @(negedge clk);
    bus.i_load  = 1'b0;
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
  endtask

  task automatic load(logic [WIDTH-1:0] p, int l,
                      logic lp);
    bus.i_load    = 1'b1;
    bus.i_pattern = p;
    bus.i_len     = LW'(l);
    bus.i_loop    = lp;
  endtask

  function automatic logic [3:0] outs();
    return {bus.o_val, bus.o_vld,
            bus.o_busy, bus.o_done};
  endfunction

  initial begin
    logic [31:0] word;
    logic [23:0] w24;
    logic [4:0]  w5;
    logic        any_done;
    int          cnt;
    chk_cnt  = 0;
    pass_cnt = 0;
    rst = 1'b1;
    bus.i_load = 0; bus.i_pattern = '0;
    bus.i_len = '0; bus.i_loop = 0;
    bus.i_start = 0; bus.i_stop = 0;
    repeat (3) step();
    chk("reset_outs", 64'(outs()), 64'h0);
    rst = 1'b0;
    step();

    // start with nothing loaded
    bus.i_start = 1'b1;
    step();
    repeat (3) step();
    chk("start_no_load_vld", 64'(bus.o_vld), 64'h0);

    // full 32-bit single pass
    load(32'hAAAA_B2CD, 32, 1'b0);
    step();
    bus.i_start = 1'b1;
    step();
    word = '0;
    for (int i = 0; i < 32; i++) begin
      word[i] = bus.o_val;
      step();
    end
    chk("pass32_bits", 64'(word), 64'hAAAA_B2CD);
    chk("pass32_done", 64'(outs()), 64'h1);
    step();
    chk("pass32_after", 64'(outs()), 64'h0);

    // looping 8-bit pattern, three passes
    load(32'h0000_00B2, 8, 1'b1);
    step();
    bus.i_start = 1'b1;
    step();
    any_done = 0;
    w24 = '0;
    for (int i = 0; i < 24; i++) begin
      w24[i] = bus.o_val;
      any_done |= bus.o_done | ~bus.o_vld;
      step();
    end
    chk("loop8_bits", 64'(w24), 64'hB2B2B2);
    chk("loop8_nogap_nodone", 64'(any_done), 64'h0);
    bus.i_stop = 1'b1;
    step();
    chk("loop8_stop", 64'(outs()), 64'h0);

    // abort after 5 bits, load in RUN ignored
    load(32'h0000_5A3C, 16, 1'b0);
    step();
    bus.i_start = 1'b1;
    step();
    w5 = '0;
    for (int i = 0; i < 5; i++) begin
      w5[i] = bus.o_val;
      if (i == 1)
        load(32'hFFFF_FFFF, 3, 1'b1);
      if (i == 4)
        bus.i_stop = 1'b1;
      step();
    end
    chk("abort_bits", 64'(w5), 64'h1C);
    chk("abort_outs", 64'(outs()), 64'h0);

    // len 40 clamps to 32
    load(32'h1234_5678, 40, 1'b0);
    bus.i_start = 1'b1;
    step();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.o_vld) break;
      cnt++;
      step();
    end
    chk("clamp40_bits", 64'(cnt), 64'd32);
    load(32'hFFFF_FFFF, 0, 1'b1);
    step();
    bus.i_start = 1'b1;
    step();
    step();
    chk("len0_idle", 64'(outs()), 64'h0);

    // reset mid-loop, later start ignored
    load(32'h0000_1ABC, 13, 1'b1);
    step();
    bus.i_start = 1'b1;
    step();
    repeat (10) step();
    chk("pre_rst_vld", 64'(bus.o_vld), 64'h1);
    rst = 1'b1;
    step();
    chk("rst_outs", 64'(outs()), 64'h0);
    rst = 1'b0;
    bus.i_start = 1'b1;
    step();
    step();
    chk("rst_start_ign", 64'(bus.o_vld), 64'h0);

    // load+start together, then stop+start
    load(32'h0000_0053, 7, 1'b0);
    bus.i_start = 1'b1;
    step();
    chk("ldst_first", 64'(outs()), 64'hE);
    repeat (10) step();
    bus.i_start = 1'b1;
    bus.i_stop  = 1'b1;
    step();
    step();
    chk("stop_wins", 64'(bus.o_vld), 64'h0);

    // len 1 looping is a constant stream
    load(32'h0000_0001, 1, 1'b1);
    bus.i_start = 1'b1;
    step();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_val && bus.o_vld) cnt++;
      step();
    end
    chk("len1_loop", 64'(cnt), 64'd10);
    bus.i_stop = 1'b1;
    step();

    // stop on last bit suppresses done
    load(32'h0000_000F, 4, 1'b0);
    bus.i_start = 1'b1;
    step();
    repeat (3) step();
    bus.i_stop = 1'b1;
    step();
    chk("stop_last_nodone", 64'(outs()), 64'h0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      bus.i_load  = ($urandom_range(0, 9) == 0);
      bus.i_pattern = $urandom;
      bus.i_len   = LW'($urandom_range(0, 40));
      bus.i_loop  = $urandom_range(0, 1) == 1;
      bus.i_start = ($urandom_range(0, 7) == 0);
      bus.i_stop  = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
